// File: rtl/mips_pkg.sv
// Shared core constants: register-file geometry and write-back requester indices.
package mips_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo N and
// grants the first asserted request.
module rr_arbiter #(
    parameter int N = 3,
    localparam int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [LW-1:0] idx
);

    localparam int SW = LW + 1;

    logic [SW-1:0] sum_s;
    logic [LW-1:0] cand_s;
    logic          found_s;

    // Priority search starting just after the previous winner
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int off = 1; off <= N; off++) begin
            // sum never exceeds 2N-1, so one conditional subtract is a full modulo
            sum_s = {1'b0, last} + SW'(off);
            if (sum_s >= SW'(N)) begin
                cand_s = LW'(sum_s - SW'(N));
            end else begin
                cand_s = sum_s[LW-1:0];
            end
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                idx           = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter for the write-back requesters, with a
// pending-write scoreboard driving decode hazard and bypass signals.
module rf_wb_arbiter
    import mips_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rf_we,
    output logic [AW-1:0]       rf_addr,
    output logic [DW-1:0]       rf_data,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [AW-1:0]       chk_addr_a,
    input  logic [AW-1:0]       chk_addr_b,
    output logic                hazard_a,
    output logic                hazard_b,
    output logic                byp_a,
    output logic                byp_b,
    output logic [NUM_REGS-1:0] pending
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [LW-1:0]       last_r;
    logic [NREQ-1:0]     grant_s;
    logic [LW-1:0]       gidx_s;
    logic [NREQ-1:0]     ready_s;
    logic                xfer_s;
    logic [AW-1:0]       sel_addr_s;
    logic [DW-1:0]       sel_data_s;
    logic                rf_we_r;
    logic [AW-1:0]       rf_addr_r;
    logic [DW-1:0]       rf_data_r;
    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (req_valid),
        .last  (last_r),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    // Grants are suppressed while reset is held so no transfer is ever seen
    always_comb begin
        ready_s = '0;
        if (reset) begin
            ready_s = '0;
        end else begin
            ready_s = grant_s;
        end
    end

    assign xfer_s = |ready_s;

    // AND-OR mux of the granted requester's address and data
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | (req_addr[i*AW +: AW] & {AW{ready_s[i]}});
            sel_data_s = sel_data_s | (req_data[i*DW +: DW] & {DW{ready_s[i]}});
        end
    end

    // Write-port drive register and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_r   <= 1'b0;
            rf_addr_r <= '0;
            rf_data_r <= '0;
            last_r    <= LW'(NREQ - 1);
        end else begin
            rf_we_r <= xfer_s;
            if (xfer_s) begin
                rf_addr_r <= sel_addr_s;
                rf_data_r <= sel_data_s;
                last_r    <= gidx_s;
            end
        end
    end

    // Scoreboard next state: a new reservation outranks a same-cycle commit
    always_comb begin
        pending_nxt_s = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            pending_nxt_s[k] = (rsv_valid && (rsv_addr == AW'(k)) && (k != 0))
                             | (pending_r[k] & ~(rf_we_r && (rf_addr_r == AW'(k))));
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
        end
    end

    // Decode-side forwarding and stall detection; register 0 is never tracked
    always_comb begin
        byp_a    = rf_we_r && (rf_addr_r == chk_addr_a) && (chk_addr_a != '0);
        byp_b    = rf_we_r && (rf_addr_r == chk_addr_b) && (chk_addr_b != '0);
        hazard_a = pending_r[chk_addr_a] && !byp_a;
        hazard_b = pending_r[chk_addr_b] && !byp_b;
    end

    assign req_ready = ready_s;
    assign rf_we     = rf_we_r;
    assign rf_addr   = rf_addr_r;
    assign rf_data   = rf_data_r;
    assign pending   = pending_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued at handshake and
// checked when the register-file port fires.
module tb_rf_wb_arbiter;
    import mips_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rf_we;
    logic [AW-1:0]       rf_addr;
    logic [DW-1:0]       rf_data;
    logic                rsv_valid;
    logic [AW-1:0]       rsv_addr;
    logic [AW-1:0]       chk_addr_a;
    logic [AW-1:0]       chk_addr_b;
    logic                hazard_a;
    logic                hazard_b;
    logic                byp_a;
    logic                byp_b;
    logic [NUM_REGS-1:0] pending;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t q[$];
    int  total = 0;
    int  bad   = 0;

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .chk_addr_a (chk_addr_a),
        .chk_addr_b (chk_addr_b),
        .hazard_a   (hazard_a),
        .hazard_b   (hazard_b),
        .byp_a      (byp_a),
        .byp_b      (byp_b),
        .pending    (pending)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic exp_grant(input int g, input string tag);
        logic [NREQ-1:0] oh;
        wr_t             w;
        oh  = NREQ'(1) << g;
        chk(tag, 64'(req_ready), 64'(oh));
        w.a = req_addr[g*AW +: AW];
        w.d = req_data[g*DW +: DW];
        q.push_back(w);
    endtask

    // Compare each register-file write against the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (q.size() == 0) begin
                chk("unexpected_we", 64'(rf_we), 64'(1'b0));
            end else begin
                wr_t w;
                w = q.pop_front();
                chk("wr_addr", 64'(rf_addr), 64'(w.a));
                chk("wr_data", 64'(rf_data), 64'(w.d));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 3'b111;
        req_addr   = '0;
        req_data   = '0;
        rsv_valid  = 1'b0;
        rsv_addr   = 5'd0;
        chk_addr_a = 5'd0;
        chk_addr_b = 5'd0;
        #2;
        chk("rst_we", 64'(rf_we), 64'(1'b0));
        chk("rst_addr", 64'(rf_addr), 64'(5'd0));
        chk("rst_data", 64'(rf_data), 64'(32'd0));
        chk("rst_pending", 64'(pending), 64'(32'd0));
        chk("rst_ready", 64'(req_ready), 64'(3'b000));
        req_valid = 3'b000;
        step();
        step();
        reset = 1'b0;

        // all three valid continuously: 0,1,2,0,1,2
        set_req(0, 1'b1, 5'd1, 32'hA1A1_0001);
        set_req(1, 1'b1, 5'd2, 32'hA2A2_0002);
        set_req(2, 1'b1, 5'd3, 32'hA3A3_0003);
        for (int c = 0; c < 6; c++) begin
            settle();
            exp_grant(c % 3, "rr_cont");
            step();
        end
        // each released after its grant
        for (int c = 0; c < 3; c++) begin
            settle();
            exp_grant(c, "rr_release");
            step();
            req_valid[c] = 1'b0;
        end
        settle();
        chk("idle_ready", 64'(req_ready), 64'(3'b000));

        // two contenders alternate
        set_req(0, 1'b1, 5'd4, 32'hB0B0_0000);
        set_req(2, 1'b1, 5'd6, 32'hB2B2_0002);
        for (int c = 0; c < 4; c++) begin
            settle();
            exp_grant((c % 2 == 0) ? 0 : 2, "rr_two");
            step();
        end
        req_valid = 3'b000;

        // single ALU write
        set_req(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
        settle();
        exp_grant(WB_ALU, "single_grant");
        step();
        req_valid = 3'b000;
        settle();
        chk("single_we", 64'(rf_we), 64'(1'b1));
        chk("single_addr", 64'(rf_addr), 64'(5'd3));
        chk("single_data", 64'(rf_data), 64'(32'hDEAD_BEEF));
        chk("single_ready_off", 64'(req_ready), 64'(3'b000));
        step();
        settle();
        chk("single_we_off", 64'(rf_we), 64'(1'b0));
        chk("single_addr_hold", 64'(rf_addr), 64'(5'd3));

        // reserve 5, then load unit commits it
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        step();
        rsv_valid  = 1'b0;
        chk_addr_a = 5'd5;
        settle();
        chk("sb_pend5", 64'(pending), 64'(32'h0000_0020));
        chk("sb_haz5", 64'(hazard_a), 64'(1'b1));
        chk("sb_byp5_off", 64'(byp_a), 64'(1'b0));
        set_req(WB_LOAD, 1'b1, 5'd5, 32'h5555_5555);
        settle();
        exp_grant(WB_LOAD, "sb_load_grant");
        step();
        req_valid = 3'b000;
        settle();
        chk("sb_byp5", 64'(byp_a), 64'(1'b1));
        chk("sb_haz5_off", 64'(hazard_a), 64'(1'b0));
        step();
        settle();
        chk("sb_clear5", 64'(pending), 64'(32'd0));
        chk("sb_haz5_clear", 64'(hazard_a), 64'(1'b0));
        chk("sb_byp5_clear", 64'(byp_a), 64'(1'b0));

        // same-cycle reserve and commit of 7: set wins
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        step();
        rsv_valid  = 1'b0;
        chk_addr_a = 5'd7;
        set_req(WB_ALU, 1'b1, 5'd7, 32'h0000_0077);
        settle();
        chk("sim_pend7", 64'(pending), 64'(32'h0000_0080));
        exp_grant(WB_ALU, "sim_grant");
        step();
        req_valid = 3'b000;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        settle();
        chk("sim_byp7", 64'(byp_a), 64'(1'b1));
        step();
        rsv_addr   = 5'd0;
        chk_addr_b = 5'd0;
        settle();
        chk("sim_set_wins", 64'(pending), 64'(32'h0000_0080));
        chk("r0_haz_b", 64'(hazard_b), 64'(1'b0));
        chk("r0_byp_b", 64'(byp_b), 64'(1'b0));
        step();
        rsv_valid = 1'b0;
        settle();
        chk("rsv0_nochange", 64'(pending), 64'(32'h0000_0080));
        chk("sim_haz7", 64'(hazard_a), 64'(1'b1));

        // retire 7 through the load unit
        set_req(WB_LOAD, 1'b1, 5'd7, 32'h7007_7007);
        settle();
        exp_grant(WB_LOAD, "ret7_grant");
        step();
        req_valid = 3'b000;
        step();
        settle();
        chk("ret7_clear", 64'(pending), 64'(32'd0));

        // write to register 0 passes through, never tracked
        set_req(WB_ALU, 1'b1, 5'd0, 32'h0000_1234);
        chk_addr_a = 5'd0;
        settle();
        exp_grant(WB_ALU, "r0_grant");
        step();
        req_valid = 3'b000;
        settle();
        chk("r0_we", 64'(rf_we), 64'(1'b1));
        chk("r0_addr", 64'(rf_addr), 64'(5'd0));
        chk("r0_byp_a", 64'(byp_a), 64'(1'b0));
        chk("r0_haz_a", 64'(hazard_a), 64'(1'b0));
        step();
        settle();
        chk("r0_pending", 64'(pending[0]), 64'(1'b0));

        // reset mid-stream with a write in flight and pending=6
        rsv_valid = 1'b1;
        rsv_addr  = 5'd1;
        step();
        rsv_addr = 5'd2;
        step();
        rsv_valid = 1'b0;
        set_req(WB_ALU, 1'b1, 5'd9, 32'h0000_0099);
        settle();
        exp_grant(WB_ALU, "mid_grant");
        step();
        settle();
        chk("mid_we", 64'(rf_we), 64'(1'b1));
        chk("mid_pending", 64'(pending), 64'(32'h0000_0006));
        chk("mid_queue", 64'(q.size()), 64'(1));
        reset = 1'b1;
        q.delete();
        settle();
        chk("mid_rst_we", 64'(rf_we), 64'(1'b0));
        chk("mid_rst_pending", 64'(pending), 64'(32'd0));
        chk("mid_rst_ready", 64'(req_ready), 64'(3'b000));
        chk("mid_rst_addr", 64'(rf_addr), 64'(5'd0));
        req_valid = 3'b000;
        step();
        step();
        reset = 1'b0;
        step();
        settle();
        chk("post_we", 64'(rf_we), 64'(1'b0));
        chk("post_queue", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
